// File: rtl/writeback_unit.sv
// MIPS write-back stage: MEM/WB pipeline register, result select with load
// extraction, register-file write port, misaligned-load flag and retire counter.
module writeback_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic              in_link,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [4:0]        in_dest_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus4,
    output logic              RegWrite,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_valid,
    output logic              load_misaligned,
    output logic [CNT_W-1:0]  retired_count
);

    logic              valid_q;
    logic              fresh_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic              link_q;
    logic [1:0]        load_size_q;
    logic              load_unsigned_q;
    logic [4:0]        dest_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] pc_q;
    logic [CNT_W-1:0]  count_q;

    // fresh marks the first cycle of an entry so a stalled entry writes only once
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= 1'b0;
            fresh_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            link_q          <= 1'b0;
            load_size_q     <= '0;
            load_unsigned_q <= 1'b0;
            dest_q          <= '0;
            alu_q           <= '0;
            mem_q           <= '0;
            pc_q            <= '0;
            count_q         <= '0;
        end else if (!stall) begin
            valid_q         <= in_valid;
            fresh_q         <= in_valid;
            reg_write_q     <= in_RegWrite;
            mem_to_reg_q    <= in_MemtoReg;
            link_q          <= in_link;
            load_size_q     <= in_load_size;
            load_unsigned_q <= in_load_unsigned;
            dest_q          <= in_dest_reg;
            alu_q           <= in_alu_result;
            mem_q           <= in_mem_data;
            pc_q            <= in_pc_plus4;
            if (in_valid)
                count_q <= count_q + CNT_W'(1);
        end else begin
            fresh_q <= 1'b0;
        end
    end

    logic [1:0]        offset;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result;
    logic              misaligned;

    always_comb begin
        offset = alu_q[1:0];
        case (offset)
            2'd0:    byte_lane = mem_q[7:0];
            2'd1:    byte_lane = mem_q[15:8];
            2'd2:    byte_lane = mem_q[23:16];
            default: byte_lane = mem_q[31:24];
        endcase
        half_lane = alu_q[1] ? mem_q[31:16] : mem_q[15:0];

        case (load_size_q)
            2'b10:   load_data = {{(DATA_W-8){~load_unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{(DATA_W-16){~load_unsigned_q & half_lane[15]}}, half_lane};
            default: load_data = mem_q;
        endcase

        if (link_q)
            result = pc_q;
        else if (mem_to_reg_q)
            result = load_data;
        else
            result = alu_q;

        misaligned = valid_q & mem_to_reg_q & ~link_q &
                     (((load_size_q == 2'b01) & offset[0]) |
                      (((load_size_q == 2'b00) | (load_size_q == 2'b11)) & (offset != 2'b00)));
    end

    always_comb begin
        load_misaligned = misaligned;
        wb_valid        = valid_q;
        RegWrite        = valid_q & fresh_q & reg_write_q & (dest_q != 5'd0) & ~misaligned;
        write_reg       = valid_q ? dest_q : '0;
        write_data      = valid_q ? result : '0;
        retired_count   = count_q;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed steps from the test plan
// followed by randomized traffic checked against a behavioural model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset, stall, in_valid, in_RegWrite, in_MemtoReg, in_link;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [4:0]  in_dest_reg;
    logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
    logic        RegWrite, wb_valid, load_misaligned;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [3:0]  retired_count;

    int checks = 0;
    int errors = 0;

    // Model state: the last accepted instruction plus bookkeeping
    logic        m_valid, m_fresh, m_rw, m_m2r, m_link, m_uns;
    logic [1:0]  m_size;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_mem, m_pc;
    logic [3:0]  m_count;

    writeback_unit #(.DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
        .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_link(in_link),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .in_dest_reg(in_dest_reg), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .wb_valid(wb_valid), .load_misaligned(load_misaligned),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_misaligned();
        int off = int'(m_alu % 4);
        if (!m_valid || !m_m2r || m_link) return 1'b0;
        if (m_size == 2'b01) return (off % 2) != 0;
        if (m_size == 2'b10) return 1'b0;
        return off != 0;
    endfunction

    function automatic logic [31:0] exp_data();
        int unsigned off = m_alu % 4;
        int unsigned v;
        if (!m_valid) return 32'h0;
        if (m_link) return m_pc;
        if (!m_m2r) return m_alu;
        if (m_size == 2'b10) begin
            v = (m_mem >> (8 * off)) % 256;
            if (!m_uns && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (m_size == 2'b01) begin
            v = (m_mem >> (16 * (off / 2))) % 65536;
            if (!m_uns && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return m_mem;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [1:0] size, input logic uns, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        in_valid = v; in_RegWrite = rw; in_MemtoReg = m2r; in_link = lnk;
        in_load_size = size; in_load_unsigned = uns; in_dest_reg = dest;
        in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1),
              5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
    endtask

    // Advance one clock: update model with the accepted inputs, then compare all outputs
    task automatic step();
        logic exp_mis, exp_rw;
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_fresh = 0; m_rw = 0; m_m2r = 0; m_link = 0; m_uns = 0;
            m_size = 0; m_dest = 0; m_alu = 0; m_mem = 0; m_pc = 0; m_count = 0;
        end else if (!stall) begin
            m_valid = in_valid; m_fresh = in_valid; m_rw = in_RegWrite; m_m2r = in_MemtoReg;
            m_link = in_link; m_size = in_load_size; m_uns = in_load_unsigned;
            m_dest = in_dest_reg; m_alu = in_alu_result; m_mem = in_mem_data; m_pc = in_pc_plus4;
            if (in_valid) m_count = m_count + 1;
        end else begin
            m_fresh = 0;
        end
        #1;
        exp_mis = exp_misaligned();
        exp_rw  = m_valid && m_fresh && m_rw && (m_dest != 0) && !exp_mis;
        check("wb_valid", 64'(wb_valid), 64'(m_valid));
        check("load_misaligned", 64'(load_misaligned), 64'(exp_mis));
        check("RegWrite", 64'(RegWrite), 64'(exp_rw));
        check("write_reg", 64'(write_reg), m_valid ? 64'(m_dest) : 64'd0);
        check("write_data", 64'(write_data), 64'(exp_data()));
        check("retired_count", 64'(retired_count), 64'(m_count));
        @(negedge clk);
    endtask

    initial begin
        reset = 1; stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        step();
        check("reset_count", 64'(retired_count), 64'd0);
        reset = 0;

        drive(1, 1, 0, 0, 2'b00, 0, 5'd3, 32'h0000_000D, 0, 0);
        step();
        check("first_write_en", 64'(RegWrite), 64'd1);
        check("first_write_reg", 64'(write_reg), 64'd3);
        check("first_write_data", 64'(write_data), 64'd13);
        check("first_count", 64'(retired_count), 64'd1);

        drive(1, 1, 0, 0, 2'b00, 0, 5'd0, 32'h0000_000D, 0, 0);
        step();
        check("zero_dest_en", 64'(RegWrite), 64'd0);
        check("zero_dest_data", 64'(write_data), 64'd13);
        check("zero_dest_count", 64'(retired_count), 64'd2);

        drive(1, 1, 1, 0, 2'b10, 0, 5'd4, 32'h0000_1000, 32'h80F0_7F81, 0);
        step();
        check("lb_off0", 64'(write_data), 64'hFFFF_FF81);
        drive(1, 1, 1, 0, 2'b10, 1, 5'd4, 32'h0000_1001, 32'h80F0_7F81, 0);
        step();
        check("lbu_off1", 64'(write_data), 64'h0000_007F);
        drive(1, 1, 1, 0, 2'b01, 0, 5'd4, 32'h0000_1002, 32'h80F0_7F81, 0);
        step();
        check("lh_off2", 64'(write_data), 64'hFFFF_80F0);
        drive(1, 1, 1, 0, 2'b01, 1, 5'd4, 32'h0000_1002, 32'h80F0_7F81, 0);
        step();
        check("lhu_off2", 64'(write_data), 64'h0000_80F0);

        drive(1, 1, 1, 0, 2'b01, 0, 5'd6, 32'h0000_1001, 32'h80F0_7F81, 0);
        step();
        check("lh_misaligned", 64'(load_misaligned), 64'd1);
        check("lh_misaligned_en", 64'(RegWrite), 64'd0);
        drive(1, 1, 1, 0, 2'b00, 0, 5'd6, 32'h0000_1002, 32'h80F0_7F81, 0);
        step();
        check("lw_misaligned", 64'(load_misaligned), 64'd1);
        check("misaligned_count", 64'(retired_count), 64'd8);

        drive(1, 1, 1, 1, 2'b00, 0, 5'd31, 32'h0000_1003, 32'h80F0_7F81, 32'h0040_0008);
        step();
        check("jal_data", 64'(write_data), 64'h0040_0008);
        check("jal_en", 64'(RegWrite), 64'd1);

        drive(1, 1, 0, 0, 2'b00, 0, 5'd7, 32'h1234_5678, 0, 0);
        step();
        check("stall_first_en", 64'(RegWrite), 64'd1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
            check("stall_held_en", 64'(RegWrite), 64'd0);
            check("stall_held_data", 64'(write_data), 64'h1234_5678);
        end
        check("stall_count", 64'(retired_count), 64'd10);
        reset = 1;
        step();
        check("reset_in_stall_valid", 64'(wb_valid), 64'd0);
        check("reset_in_stall_count", 64'(retired_count), 64'd0);
        reset = 0;
        step();
        check("after_reset_en", 64'(RegWrite), 64'd0);
        stall = 0;

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 3) == 0);
            drive_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
